bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 38 +++
 rtl/bcd_add3_digit.sv | 24 ++
 rtl/bin_to_bcd_seq.sv | 200 ++++++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD conversion and display path.
//   BCD_DIGIT_W     : width of one packed BCD digit
//   BCD_BLANK       : nibble code the 7-segment decoder renders as blank
//   BCD_NINE        : digit value used when a result saturates
//   conv_state_t    : converter FSM states (IDLE, SHIFT)
//   interior_digits : number of BCD digits needed to hold any bin_w-bit value
//   max_value       : largest value representable in a given digit count
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_BLANK   = 4'b1111;
    localparam logic [3:0]  BCD_NINE    = 4'd9;

    typedef enum logic {
        IDLE,
        SHIFT
    } conv_state_t;

    // log10(2) is about 0.30103, so 0.31 per bit plus one spare digit always
    // covers 2^bin_w - 1 for every width up to 32 bits.
    function automatic int interior_digits(input int bin_w);
        return (bin_w * 31) / 100 + 1;
    endfunction

    // 10^digits - 1, computed in 64 bits so eight digits never overflow.
    function automatic logic [63:0] max_value(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// ---------------------------------------------------------------------------
// bcd_add3_digit
// Combinational double-dabble correction for one BCD nibble: any digit of
// five or more gets three added so the following left shift carries into
// the next digit correctly.
//   din  : scratch nibble before correction
//   dout : corrected nibble
// ---------------------------------------------------------------------------
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Plain compare-and-add; a 4-bit wrap cannot occur because din <= 9 in use.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble converter: one shift per input bit, start/busy/
// done handshake, result saturates to all nines when the value does not fit
// in DIGITS decimal digits.
//
// Parameters
//   BIN_W  : binary input width (1..32)
//   DIGITS : number of BCD digits presented on bcd (1..8)
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   start    : conversion request, taken only in IDLE (including the done cycle)
//   bin      : unsigned operand, captured on the accepting edge
//   busy     : conversion in progress
//   done     : one-cycle pulse, bcd/overflow updated this cycle
//   overflow : operand exceeded 10^DIGITS-1 (held until the next done)
//   bcd      : packed result, digit 0 (units) in bits [3:0]
//
// Optional feature (macro BCD_LEADING_ZERO_BLANK_EN)
//   Leading zero digits above digit 0 are replaced by BCD_BLANK when bcd is
//   loaded; saturated results are never blanked and the reset value becomes
//   all blanks with digit 0 = 0.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

    localparam int          INT_DIGITS = interior_digits(BIN_W);
    localparam int          INT_W      = INT_DIGITS * BCD_DIGIT_W;
    localparam int          OUT_W      = DIGITS * BCD_DIGIT_W;
    localparam int          CNT_W      = 6;
    localparam logic [63:0] MAX_VAL    = max_value(DIGITS);

    // Refuse to build outside the supported parameter range.
    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin_to_bcd_seq: BIN_W must be within 1..32");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS must be within 1..8");
    end

    conv_state_t              state;
    conv_state_t              state_next;
    logic [BIN_W-1:0]         shreg;
    logic [INT_W-1:0]         scratch;
    logic [INT_W-1:0]         corr;
    logic [INT_W+BIN_W-1:0]   shifted;
    logic [INT_W-1:0]         scratch_next;
    logic [BIN_W-1:0]         shreg_next;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_pend;
    logic [63:0]              bin_wide;
    logic                     accept;
    logic                     last_shift;
    logic [OUT_W-1:0]         bcd_raw;
    logic [OUT_W-1:0]         bcd_disp;
    logic [OUT_W-1:0]         bcd_sat;
    logic [OUT_W-1:0]         bcd_rst;

    assign accept     = (state == IDLE) && start;
    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));
    assign bin_wide   = 64'(bin);
    assign bcd_sat    = {DIGITS{BCD_NINE}};

    // One correction cell per interior digit; the scratch is sized so the
    // full operand always fits, the output selection happens afterwards.
    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .din  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The corrected scratch and the operand shift as one long register, so
    // the operand MSB falls into the scratch LSB each step.
    assign shifted      = {corr, shreg} << 1;
    assign scratch_next = shifted[INT_W+BIN_W-1:BIN_W];
    assign shreg_next   = shifted[BIN_W-1:0];

    // Pick the presented digits out of the post-shift scratch, padding with
    // zero digits when more digits are shown than the operand can need, and
    // build the per-digit reset pattern alongside.
    for (genvar d = 0; d < DIGITS; d++) begin : g_out
        if (d < INT_DIGITS) begin : g_live
            assign bcd_raw[d*BCD_DIGIT_W +: BCD_DIGIT_W] = scratch_next[d*BCD_DIGIT_W +: BCD_DIGIT_W];
        end else begin : g_pad
            assign bcd_raw[d*BCD_DIGIT_W +: BCD_DIGIT_W] = '0;
        end
        if (d == 0) begin : g_rst_units
            assign bcd_rst[BCD_DIGIT_W-1:0] = '0;
        end else begin : g_rst_upper
`ifdef BCD_LEADING_ZERO_BLANK_EN
            assign bcd_rst[d*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
`else
            assign bcd_rst[d*BCD_DIGIT_W +: BCD_DIGIT_W] = '0;
`endif
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic lead_zero;

    // Walk from the most significant digit down and blank zeros until the
    // first non-zero digit; digit 0 is left alone so zero still shows "0".
    always_comb begin
        bcd_disp  = bcd_raw;
        lead_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead_zero && (bcd_raw[d*BCD_DIGIT_W +: BCD_DIGIT_W] == '0)) begin
                bcd_disp[d*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
            end else begin
                lead_zero = 1'b0;
            end
        end
    end
`else
    assign bcd_disp = bcd_raw;
`endif

    // State register; reset always returns to IDLE and aborts any conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE waits for start, SHIFT runs until the counter
    // reaches its last step. Start is not looked at while shifting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. Acceptance captures the operand and
    // its overflow verdict up front, so later changes on bin are ignored.
    // The last shift loads bcd straight from the post-shift scratch so done
    // and the new result appear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= bcd_rst;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                shreg    <= bin;
                scratch  <= '0;
                cnt      <= CNT_W'(BIN_W);
                ovf_pend <= (bin_wide > MAX_VAL);
                busy     <= 1'b1;
            end else if (state == SHIFT) begin
                shreg   <= shreg_next;
                scratch <= scratch_next;
                cnt     <= cnt - CNT_W'(1);
                if (last_shift) begin
                    bcd      <= ovf_pend ? bcd_sat : bcd_disp;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4). Expected
// results come from a decimal-arithmetic reference model and a table of
// hand-computed vectors; BCD_LEADING_ZERO_BLANK_EN selects the blanked
// expectations.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int OUT_W  = 4 * DIGITS;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [OUT_W-1:0] RST_BCD = 16'hFFF0;
`else
    localparam logic [OUT_W-1:0] RST_BCD = 16'h0000;
`endif

    typedef struct {
        int unsigned      value;
        logic [OUT_W-1:0] exp_bcd;
        logic             exp_ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [OUT_W-1:0] bcd;

    int               checks = 0;
    int               failures = 0;
    logic [OUT_W-1:0] held_bcd;
    vec_t             table_v[8];

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd      (bcd)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: decimal digits by division, saturation above 9999,
    // and optional blanking of every digit position above the value's length.
    function automatic logic [OUT_W:0] refModel(input int unsigned v);
        logic [OUT_W-1:0] r;
        int unsigned      rem;
        int unsigned      pow;
        if (v > 9999) begin
            return {1'b1, 16'h9999};
        end
        rem = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        pow = 10;
        for (int d = 1; d < DIGITS; d++) begin
            if (v < pow) begin
                r[d*4 +: 4] = 4'hF;
            end
            pow = pow * 10;
        end
`else
        pow = 0;
`endif
        return {1'b0, r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Waits for done after an accepting edge (caller sits #1 after that edge),
    // checking latency, busy while converting, result hold, and the result.
    task automatic waitDone(input int unsigned v, input logic [OUT_W-1:0] exp_bcd,
                            input logic exp_ovf, input string tag);
        int   cyc;
        logic seen;
        logic busy_ok;
        logic hold_ok;
        cyc     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!seen && cyc < BIN_W + 5) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (bcd !== held_bcd) hold_ok = 1'b0;
            end
        end
        checkOutput({tag, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, " latency"}, 32'(cyc), 32'(BIN_W));
            checkOutput({tag, " busy_while_converting"}, 32'(busy_ok), 32'd1);
            checkOutput({tag, " bcd_held_while_converting"}, 32'(hold_ok), 32'd1);
            checkOutput({tag, " busy_in_done_cycle"}, 32'(busy), 32'd0);
            checkOutput({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
            checkOutput({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        end
        held_bcd = exp_bcd;
        if (v > 32'hFFFF) $display("[TB] note: operand wider than expected");
    endtask

    // One isolated conversion: pulse start, scramble bin after acceptance,
    // wait for the result, then confirm done dropped after one cycle.
    task automatic applyStimulus(input int unsigned v, input logic [OUT_W-1:0] exp_bcd,
                                 input logic exp_ovf, input string tag);
        start = 1'b1;
        bin   = BIN_W'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = BIN_W'($urandom);
        waitDone(v, exp_bcd, exp_ovf, tag);
        @(posedge clk);
        #1;
        checkOutput({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [OUT_W:0] m;
        int unsigned    v;
        logic           late_done;

        table_v[0] = '{1234,  16'h1234, 1'b0};
        table_v[1] = '{9999,  16'h9999, 1'b0};
        table_v[2] = '{16383, 16'h9999, 1'b1};
        table_v[3] = '{10000, 16'h9999, 1'b1};
`ifdef BCD_LEADING_ZERO_BLANK_EN
        table_v[4] = '{0,     16'hFFF0, 1'b0};
        table_v[5] = '{7,     16'hFFF7, 1'b0};
        table_v[6] = '{42,    16'hFF42, 1'b0};
        table_v[7] = '{100,   16'hF100, 1'b0};
`else
        table_v[4] = '{0,     16'h0000, 1'b0};
        table_v[5] = '{7,     16'h0007, 1'b0};
        table_v[6] = '{42,    16'h0042, 1'b0};
        table_v[7] = '{100,   16'h0100, 1'b0};
`endif

        // Reset held for two cycles.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset bcd", 32'(bcd), 32'(RST_BCD));
        rst_n    = 1'b1;
        held_bcd = RST_BCD;
        @(posedge clk);
        #1;

        // Table vectors, including overflow followed by a small value.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(table_v[i].value, table_v[i].exp_bcd, table_v[i].exp_ovf,
                          $sformatf("vec%0d(%0d)", i, table_v[i].value));
        end

        // Start held high: mid-conversion starts ignored, the start in the
        // done cycle is taken, bin changes after acceptance have no effect.
        start = 1'b1;
        bin   = BIN_W'(5);
        @(posedge clk);
        #1;
        bin = BIN_W'(6);
        m = refModel(5);
        waitDone(5, m[OUT_W-1:0], m[OUT_W], "cont5");
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = BIN_W'(9876);
        m = refModel(6);
        waitDone(6, m[OUT_W-1:0], m[OUT_W], "cont6");
        @(posedge clk);
        #1;
        checkOutput("cont done_one_cycle", 32'(done), 32'd0);

        // Reset during a conversion of 4321 aborts it without a done pulse.
        start = 1'b1;
        bin   = BIN_W'(4321);
        @(posedge clk);
        #1;
        start     = 1'b0;
        late_done = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) late_done = 1'b1;
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) late_done = 1'b1;
        end
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort bcd", 32'(bcd), 32'(RST_BCD));
        rst_n = 1'b1;
        repeat (BIN_W + 2) begin
            @(posedge clk);
            #1;
            if (done) late_done = 1'b1;
        end
        checkOutput("abort no_done", 32'(late_done), 32'd0);
        held_bcd = RST_BCD;
        m = refModel(4321);
        applyStimulus(4321, m[OUT_W-1:0], m[OUT_W], "after_abort(4321)");

        // Randomised operands against the reference model, biased toward
        // the saturation boundary every few iterations.
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 3) begin
                v = $urandom_range(10001, 9998);
            end else begin
                v = $urandom_range((1 << BIN_W) - 1, 0);
            end
            m = refModel(v);
            applyStimulus(v, m[OUT_W-1:0], m[OUT_W], $sformatf("rand%0d(%0d)", i, v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
